// File: rtl/clk_monitor.sv
// clk_monitor: measures period, high time and low time of an asynchronous
// clock (mon_in) in clk cycles, flags frequency/duty violations and detects
// a stopped clock.
// Optional build macro: CLK_MON_MINMAX_EN adds running period_min/period_max.
module clk_monitor #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EXP_PERIOD  = 10,
    parameter int PERIOD_TOL  = 1,
    parameter int EXP_HIGH    = 5,
    parameter int DUTY_TOL    = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mon_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] low_time,
    output logic             meas_valid,
    output logic             freq_err,
    output logic             duty_err,
    output logic             err_sticky,
    output logic             stalled,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max
);

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    // One extra bit so that x + TOL never wraps during the error compare.
    localparam int XW = CNT_W + 1;
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
    localparam logic [XW-1:0]    EXP_P  = XW'(EXP_PERIOD);
    localparam logic [XW-1:0]    TOL_P  = XW'(PERIOD_TOL);
    localparam logic [XW-1:0]    EXP_H  = XW'(EXP_HIGH);
    localparam logic [XW-1:0]    TOL_H  = XW'(DUTY_TOL);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   sync_q, prev_q, rise, fall;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, hi_q;
    logic                   do_meas, cap_hi, stall_set, stall_clr;
    logic [XW-1:0]          cnt_x, hi_x;
    logic                   freq_n, duty_n;

    assign sync_q = sync_chain[SYNC_STAGES-1];
    assign rise   = sync_q & ~prev_q;
    assign fall   = ~sync_q & prev_q;

    // Synchronizer chain and edge-detect flop; independent of enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_chain <= '0;
            prev_q     <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], mon_in};
            prev_q     <= sync_q;
        end
    end

    // FSM state and sample counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state, counter update and datapath strobes. A rise always beats
    // the stall threshold when both land in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_meas   = 1'b0;
        cap_hi    = 1'b0;
        stall_set = 1'b0;
        stall_clr = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
                ARM, HIGH, LOW: begin
                    if (rise) begin
                        cnt_d     = CNT_W'(1);
                        state_d   = HIGH;
                        stall_clr = 1'b1;
                        do_meas   = (state_q == LOW);
                    end else if (cnt_q >= TMO) begin
                        cnt_d     = TMO;
                        state_d   = ARM;
                        stall_set = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (state_q == HIGH && fall) begin
                            cap_hi  = 1'b1;
                            state_d = LOW;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Tolerance checks on the period/high time about to be published.
    always_comb begin
        cnt_x  = {1'b0, cnt_q};
        hi_x   = {1'b0, hi_q};
        freq_n = (cnt_x > EXP_P + TOL_P) || (cnt_x + TOL_P < EXP_P);
        duty_n = (hi_x > EXP_H + TOL_H) || (hi_x + TOL_H < EXP_H);
    end

    // Measurement, error and stall outputs; counts and error flags hold
    // across a disable, status flags clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q       <= '0;
            period     <= '0;
            high_time  <= '0;
            low_time   <= '0;
            meas_valid <= 1'b0;
            freq_err   <= 1'b0;
            duty_err   <= 1'b0;
            err_sticky <= 1'b0;
            stalled    <= 1'b0;
        end else if (!enable) begin
            meas_valid <= 1'b0;
            stalled    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            meas_valid <= do_meas;
            if (cap_hi)
                hi_q <= cnt_q;
            if (stall_set)
                stalled <= 1'b1;
            else if (stall_clr)
                stalled <= 1'b0;
            if (do_meas) begin
                period     <= cnt_q;
                high_time  <= hi_q;
                low_time   <= cnt_q - hi_q;
                freq_err   <= freq_n;
                duty_err   <= duty_n;
                err_sticky <= err_sticky | freq_n | duty_n;
            end
        end
    end

`ifdef CLK_MON_MINMAX_EN
    logic first_q;

    // Running min/max of published periods; first one after reset or
    // re-enable loads both.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_q    <= 1'b1;
            period_min <= '0;
            period_max <= '0;
        end else if (!enable) begin
            first_q <= 1'b1;
        end else if (do_meas) begin
            first_q <= 1'b0;
            if (first_q) begin
                period_min <= cnt_q;
                period_max <= cnt_q;
            end else begin
                if (cnt_q < period_min) period_min <= cnt_q;
                if (cnt_q > period_max) period_max <= cnt_q;
            end
        end
    end
`else
    assign period_min = '0;
    assign period_max = '0;
`endif

endmodule

// File: tb/tb_clk_monitor.sv
// tb_clk_monitor: table-driven directed test of clk_monitor (TIMEOUT=64),
// plus hand-written stall, enable-gap, min/max and mid-measurement reset
// sequences.
module tb_clk_monitor;

    logic        clk = 1'b0;
    logic        rst, enable, mon_in;
    logic [15:0] period, high_time, low_time, period_min, period_max;
    logic        meas_valid, freq_err, duty_err, err_sticky, stalled;

    int checks = 0;
    int errors = 0;

    // Observation bookkeeping, written only by the monitor process.
    int   cyc = 0;
    int   vcount = 0;
    int   last_valid_cyc = 0;
    int   stall_cyc = -1;
    logic stalled_d = 1'b0;

    typedef struct {
        int hi; int lo; int n; int vcnt;
        int per; int hit; int lot; int fe; int de; int st;
    } vec_t;
    vec_t tbl[8];

`ifdef CLK_MON_MINMAX_EN
    localparam int EXP_MIN  = 9;
    localparam int EXP_MAX  = 12;
    localparam int EXP_RMIN = 10;
    localparam int EXP_RMAX = 10;
`else
    localparam int EXP_MIN  = 0;
    localparam int EXP_MAX  = 0;
    localparam int EXP_RMIN = 0;
    localparam int EXP_RMAX = 0;
`endif

    always #5 clk = ~clk;

    clk_monitor #(
        .CNT_W(16), .SYNC_STAGES(2), .EXP_PERIOD(10), .PERIOD_TOL(1),
        .EXP_HIGH(5), .DUTY_TOL(1), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .mon_in(mon_in),
        .period(period), .high_time(high_time), .low_time(low_time),
        .meas_valid(meas_valid), .freq_err(freq_err), .duty_err(duty_err),
        .err_sticky(err_sticky), .stalled(stalled),
        .period_min(period_min), .period_max(period_max)
    );

    // Count valid pulses and timestamp valids and stall onsets.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (meas_valid) begin
            vcount         = vcount + 1;
            last_valid_cyc = cyc;
        end
        if (stalled && !stalled_d)
            stall_cyc = cyc;
        stalled_d = stalled;
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mon_in high for hi samples, then low for lo samples.
    task automatic drive(input int hi, input int lo);
        mon_in = 1'b1;
        tick(hi);
        mon_in = 1'b0;
        tick(lo);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_period"},     period,     0);
        check({tag, "_high"},       high_time,  0);
        check({tag, "_low"},        low_time,   0);
        check({tag, "_valid"},      meas_valid, 0);
        check({tag, "_freq_err"},   freq_err,   0);
        check({tag, "_duty_err"},   duty_err,   0);
        check({tag, "_sticky"},     err_sticky, 0);
        check({tag, "_stalled"},    stalled,    0);
        check({tag, "_pmin"},       period_min, 0);
        check({tag, "_pmax"},       period_max, 0);
    endtask

    initial begin
        int base;
        //          hi lo  n vcnt per hi lo fe de st
        tbl[0] = '{5, 5, 4, 3, 10, 5, 5, 0, 0, 0};
        tbl[1] = '{3, 7, 3, 3, 10, 3, 7, 0, 1, 1};
        tbl[2] = '{5, 5, 3, 3, 10, 5, 5, 0, 0, 1};
        tbl[3] = '{7, 6, 3, 3, 13, 7, 6, 1, 1, 1};
        tbl[4] = '{5, 6, 3, 3, 11, 5, 6, 0, 0, 1};
        tbl[5] = '{6, 6, 3, 3, 12, 6, 6, 1, 0, 1};
        tbl[6] = '{4, 4, 3, 3,  8, 4, 4, 1, 0, 1};
        tbl[7] = '{4, 5, 3, 3,  9, 4, 5, 0, 0, 1};

        rst = 1'b1; enable = 1'b0; mon_in = 1'b0;
        tick(3);
        check_zero("reset");
        rst = 1'b0;
        tick(2);
        enable = 1'b1;

        // Table vectors: last published record belongs to this pattern.
        for (int v = 0; v < 8; v++) begin
            base = vcount;
            for (int k = 0; k < tbl[v].n; k++)
                drive(tbl[v].hi, tbl[v].lo);
            check($sformatf("v%0d_count", v),    vcount - base, tbl[v].vcnt);
            check($sformatf("v%0d_period", v),   period,        tbl[v].per);
            check($sformatf("v%0d_high", v),     high_time,     tbl[v].hit);
            check($sformatf("v%0d_low", v),      low_time,      tbl[v].lot);
            check($sformatf("v%0d_freq_err", v), freq_err,      tbl[v].fe);
            check($sformatf("v%0d_duty_err", v), duty_err,      tbl[v].de);
            check($sformatf("v%0d_sticky", v),   err_sticky,    tbl[v].st);
        end

        // Stall: three good periods, then input held low.
        base = vcount;
        repeat (3) drive(5, 5);
        check("stall_pre_count", vcount - base, 3);
        check("stall_pre_flag", stalled, 0);
        for (int i = 0; i < 200 && !stalled; i++)
            tick(1);
        check("stall_flag", stalled, 1);
        @(negedge clk);
        #1;
        check("stall_delay", stall_cyc - last_valid_cyc, 64);
        tick(1);
        base = vcount;
        drive(5, 5);
        check("stall_clear", stalled, 0);
        check("stall_rearm_count", vcount - base, 0);
        drive(5, 5);
        check("stall_first_valid", vcount - base, 1);
        check("stall_first_period", period, 10);

        // Enable dropped while HIGH; bad pattern during the gap is ignored.
        mon_in = 1'b1;
        tick(5);
        enable = 1'b0;
        tick(2);
        check("gap_sticky", err_sticky, 0);
        check("gap_stalled", stalled, 0);
        check("gap_valid", meas_valid, 0);
        base = vcount;
        drive(3, 7);
        drive(3, 7);
        check("gap_count", vcount - base, 0);
        check("gap_period_hold", period, 10);
        check("gap_high_hold", high_time, 5);
        check("gap_low_hold", low_time, 5);
        check("gap_duty_hold", duty_err, 0);

        // Re-enable: periods 10, 12, 9, 10 then a closing rise.
        enable = 1'b1;
        base = vcount;
        drive(5, 5);
        check("reen_first_count", vcount - base, 0);
        drive(6, 6);
        drive(5, 4);
        drive(5, 5);
        mon_in = 1'b1;
        tick(5);
        check("reen_count", vcount - base, 4);
        check("reen_period", period, 10);
        check("reen_freq_err", freq_err, 0);
        check("reen_sticky", err_sticky, 1);
        check("reen_pmin", period_min, EXP_MIN);
        check("reen_pmax", period_max, EXP_MAX);

        // Reset in the middle of a high phase.
        rst = 1'b1;
        tick(1);
        check_zero("midrst");
        rst = 1'b0;
        mon_in = 1'b0;
        tick(3);
        base = vcount;
        drive(5, 5);
        check("midrst_first_count", vcount - base, 0);
        drive(5, 5);
        check("midrst_count", vcount - base, 1);
        check("midrst_period", period, 10);
        check("midrst_pmin", period_min, EXP_RMIN);
        check("midrst_pmax", period_max, EXP_RMAX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/clk_monitor.md
Name: clk_monitor

Overview:
- Measures a generated clock, such as the output of clock_gen, by oversampling it with a faster system clock.
- Reports period, high time and low time in system-clock cycles for each period.
- Flags frequency and duty-cycle violations against expected values, and detects a stopped clock.
- Sits directly downstream of the clock generator in benches and on-chip self-check paths.

Parameters:
- CNT_W, 16: width of all count outputs and of the internal counter.
- SYNC_STAGES, 2: number of synchronizer flops on mon_in; minimum 2.
- EXP_PERIOD, 10: expected period in clk cycles.
- PERIOD_TOL, 1: allowed absolute period deviation in cycles.
- EXP_HIGH, 5: expected high time in clk cycles.
- DUTY_TOL, 1: allowed absolute high-time deviation in cycles.
- TIMEOUT, 1024: cycles without a rising edge before stall is declared; must be less than 2^CNT_W.

Ports:
- clk  in  1  system sampling clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  monitor enable; low forces IDLE.
- mon_in  in  1  monitored clock, asynchronous to clk.
- period  out  CNT_W  last measured period.
- high_time  out  CNT_W  last measured high time.
- low_time  out  CNT_W  last measured low time (period − high_time).
- meas_valid  out  1  one-cycle pulse when the three counts update.
- freq_err  out  1  last period outside EXP_PERIOD ± PERIOD_TOL.
- duty_err  out  1  last high time outside EXP_HIGH ± DUTY_TOL.
- err_sticky  out  1  set by any freq_err or duty_err.
- stalled  out  1  no rising edge for TIMEOUT cycles.
- period_min  out  CNT_W  optional; see Optional Feature.
- period_max  out  CNT_W  optional; see Optional Feature.

Behaviour:
- Reset (clk edge with rst=1): all outputs 0, all synchronizer flops 0, state IDLE, cnt_q=0.
- Synchronizer:
  - A chain of SYNC_STAGES flops produces sync_q; it runs whenever rst=0.
  - prev_q <= sync_q.
  - rise = sync_q & ~prev_q; fall = ~sync_q & prev_q.
  - Latency from a mon_in edge to rise/fall is SYNC_STAGES or SYNC_STAGES+1 cycles.
- States:
  - IDLE: when enable=1, go to ARM. cnt_q held at 0.
  - ARM: discard any fall. On rise, cnt_q<=1 and go to HIGH. No measurement is reported for the partial first period.
  - HIGH: cnt_q<=cnt_q+1. On fall, hi_q<=cnt_q and go to LOW.
  - LOW: cnt_q<=cnt_q+1. On rise:
    - period<=cnt_q, high_time<=hi_q, low_time<=cnt_q−hi_q, meas_valid<=1;
    - errors updated as below;
    - cnt_q<=1 and go to HIGH.
- Counting rule: cnt_q equals the number of samples since the last rise. Example: sync_q high for 5 samples then low for 5 gives high_time=5, low_time=5, period=10.
- Error rules:
  - freq_err and duty_err update only together with meas_valid and hold between updates.
  - Comparison is |x−EXP| > TOL, computed without underflow (compare in both directions).
  - err_sticky <= err_sticky | freq_err_next | duty_err_next.
- meas_valid is high exactly one cycle per completed period; it is never asserted twice back-to-back unless period=1 (impossible with SYNC_STAGES≥2; not required).
- Stall:
  - In ARM, HIGH or LOW, if cnt_q reaches TIMEOUT with no rise: stalled<=1, cnt_q saturates at TIMEOUT, go to ARM.
  - In ARM, cnt_q also counts from entry, so stall is detected on a flat input after enable.
  - stalled clears on the next rise.
  - A level stuck high or low both produce a stall.
- enable deasserted in any state:
  - Next cycle: state IDLE, cnt_q=0, meas_valid=0, stalled=0, err_sticky=0.
  - period, high_time, low_time, freq_err and duty_err hold their last values.
- Simultaneous rise and stall threshold in the same cycle: rise wins (measurement reported, stalled stays 0).
- rst mid-measurement: returns to the reset state next edge; no partial measurement is reported.

Optional Feature:
- Macro: CLK_MON_MINMAX_EN.
- Defined:
  - period_min and period_max update on every meas_valid.
  - The first valid after reset or after enable rises loads both with period.
  - After that, period_min=min(period_min, period) and period_max=max(period_max, period).
  - Reset value 0.
- Undefined: both ports are driven constant 0; no min/max logic is synthesized.

Test Plan:
- mon_in toggles every 5 clk cycles, defaults → from the 2nd rise on, each meas_valid shows period=10, high_time=5, low_time=5, freq_err=0, duty_err=0, err_sticky=0.
- mon_in high 3 / low 7 cycles → period=10, high_time=3, duty_err=1, freq_err=0, err_sticky=1 stays set after returning to 5/5.
- mon_in period 13 (7 high / 6 low) → period=13, freq_err=1, duty_err=1 (7−5=2>1).
- mon_in held 0 after 3 good periods, TIMEOUT=64 → stalled=1 exactly 64 samples after the last rise; next toggle → stalled=0, first meas_valid only after two rises.
- enable dropped mid-HIGH, then raised → no meas_valid during the gap; counts hold old values; err_sticky=0; first new valid after the second rise.
- CLK_MON_MINMAX_EN defined, periods 10, 12, 9, 10 → after the 4th valid, period_min=9, period_max=12; undefined → both remain 0.
